// File: rtl/jigl_ws_if.sv
// CPU-side bus bundle for the jigl_ws glue block: address, bank byte, cycle qualifiers,
// strobes, chip selects, RDY and the wait-state FSM debug view.
interface jigl_ws_if #(
   parameter int BANK_W   = 8,
   parameter int IO_SLOTS = 8
);
   // RDY handshake: a qualifying cycle seen in IDLE may drop RDY; while RDY=0 the CPU
   // holds address, bank and nRW stable and the glue holds BA and all selects.
   logic [15:5]          ADDR;
   logic [BANK_W-1:0]    DB;
   logic                 nRW;
   logic                 VDA;
   logic                 VPA;
   logic [BANK_W-1:0]    BA;
   logic                 nRD;
   logic                 nWR;
   logic                 nROMCS;
   logic                 nRAM1CS;
   logic                 nRAM2CS;
   logic [IO_SLOTS-1:0]  nIOSEL;
   logic                 RDY;
   logic                 ws_wait_dbg;

   modport master (
      output ADDR, DB, nRW, VDA, VPA,
      input  BA, nRD, nWR, nROMCS, nRAM1CS, nRAM2CS, nIOSEL, RDY, ws_wait_dbg
   );

   modport slave (
      input  ADDR, DB, nRW, VDA, VPA,
      output BA, nRD, nWR, nROMCS, nRAM1CS, nRAM2CS, nIOSEL, RDY, ws_wait_dbg
   );
endinterface

// File: rtl/jigl_ws.sv
// 65816 glue: bank latch, ROM/RAM1/RAM2/I/O decode and per-region wait-state RDY stretcher.
// Optional JIGL_WSREG_EN turns I/O slot 0 into a writable ROM wait-state register.
module jigl_ws #(
   parameter int BANK_W   = 8,
   parameter int IO_SLOTS = 8,
   parameter int WS_W     = 3,
   parameter int ROM_WS   = 2,
   parameter int RAM_WS   = 0,
   parameter int IO_WS    = 1
) (
   input logic     PHI2,
   input logic     RESET,
   jigl_ws_if.slave bus
);
   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_e;

   localparam logic [WS_W-1:0] ROM_WS_T = WS_W'(ROM_WS);
   localparam logic [WS_W-1:0] RAM_WS_T = WS_W'(RAM_WS);
   localparam logic [WS_W-1:0] IO_WS_T  = WS_W'(IO_WS);

   state_e              state_q, state_d;
   logic [WS_W-1:0]     count_q, count_d;
   logic [BANK_W-1:0]   ba_q, ba_d;
   logic [WS_W-1:0]     rom_ws_cur;
   logic [WS_W-1:0]     region_ws;
   logic                bank0, lowrom, highrom, io, ram, ram1, ram2;
   logic [IO_SLOTS-1:0] io_sel_n;
   logic                unused_addr;

   assign unused_addr = ^bus.ADDR[10:8];

   // Decode runs on the latched bank, so it is stable across any wait states.
   always_comb begin
      bank0   = (ba_q == '0);
      lowrom  = bank0 & (bus.ADDR[15:11] == 5'b11111);
      highrom = ba_q[BANK_W-1];
      io      = bank0 & (bus.ADDR[15:11] == 5'b11110) & bus.VDA;
      ram     = ~highrom & ~lowrom & ~io;
      ram1    = ram & ~ba_q[BANK_W-2];
      ram2    = ram & ba_q[BANK_W-2];
   end

   always_comb begin
      io_sel_n = '1;
      for (int k = 0; k < IO_SLOTS; k++) begin
         if (io && (bus.ADDR[7:5] == 3'(k))) io_sel_n[k] = 1'b0;
      end
`ifdef JIGL_WSREG_EN
      io_sel_n[0] = 1'b1;
`endif
   end

`ifdef JIGL_WSREG_EN
   logic [WS_W-1:0] rom_ws_q, rom_ws_d;

   always_comb begin
      rom_ws_d = rom_ws_q;
      if (state_q == IDLE && io && bus.ADDR[7:5] == 3'd0 && !bus.nRW)
         rom_ws_d = bus.DB[WS_W-1:0];
   end

   always_ff @(posedge PHI2) begin
      if (RESET) rom_ws_q <= ROM_WS_T;
      else       rom_ws_q <= rom_ws_d;
   end

   assign rom_ws_cur = rom_ws_q;
`else
   assign rom_ws_cur = ROM_WS_T;
`endif

   always_comb begin
      if (lowrom || highrom) region_ws = rom_ws_cur;
      else if (io)           region_ws = IO_WS_T;
      else                   region_ws = RAM_WS_T;
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      ba_d    = ba_q;
      case (state_q)
         IDLE: begin
            if (bus.VDA || bus.VPA) begin
               ba_d = bus.DB;
               if (region_ws != '0) begin
                  count_d = region_ws;
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            count_d = count_q - WS_W'(1);
            if (count_q == WS_W'(1)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge PHI2) begin
      if (RESET) begin
         state_q <= IDLE;
         count_q <= '0;
         ba_q    <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         ba_q    <= ba_d;
      end
   end

   assign bus.BA          = ba_q;
   assign bus.nRD         = ~(PHI2 & bus.nRW);
   assign bus.nWR         = ~(PHI2 & ~bus.nRW);
   assign bus.nROMCS      = ~(lowrom | highrom);
   assign bus.nRAM1CS     = ~ram1;
   assign bus.nRAM2CS     = ~ram2;
   assign bus.nIOSEL      = io_sel_n;
   assign bus.RDY         = (state_q == IDLE);
   assign bus.ws_wait_dbg = (state_q == WAIT);
endmodule

// File: tb/tb_jigl_ws.sv
// Randomised bench for jigl_ws against an address-arithmetic reference model.
module tb_jigl_ws;
   localparam int BANK_W   = 8;
   localparam int IO_SLOTS = 8;
   localparam int WS_W     = 3;
   localparam int ROM_WS   = 2;
   localparam int RAM_WS   = 0;
   localparam int IO_WS    = 5;

   logic phi2;
   logic reset;
   int   n_vec;
   int   n_bad;

   // reference model state
   int m_ba;
   int m_wait;
   int m_rom_ws;

   jigl_ws_if #(.BANK_W(BANK_W), .IO_SLOTS(IO_SLOTS)) bus ();

   jigl_ws #(
      .BANK_W(BANK_W), .IO_SLOTS(IO_SLOTS), .WS_W(WS_W),
      .ROM_WS(ROM_WS), .RAM_WS(RAM_WS), .IO_WS(IO_WS)
   ) dut (
      .PHI2  (phi2),
      .RESET (reset),
      .bus   (bus)
   );

   initial phi2 = 1'b0;
   always #5 phi2 = ~phi2;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One bus cycle: drive at PHI2 fall, check pre-edge outputs, clock, advance the model.
   task automatic step(input bit rst, input logic [10:0] a, input logic [7:0] d,
                       input bit rw, input bit vda, input bit vpa);
      int  addr, slot, ws;
      bit  bank0, lowrom, highrom, io, ram, ram2, wsreg;
      logic [IO_SLOTS-1:0] exp_sel;
      @(negedge phi2);
      reset   = rst;
      bus.ADDR = a;
      bus.DB   = d;
      bus.nRW  = rw;
      bus.VDA  = vda;
      bus.VPA  = vpa;
      #1;
`ifdef JIGL_WSREG_EN
      wsreg = 1'b1;
`else
      wsreg = 1'b0;
`endif
      addr    = int'(a) * 32;
      slot    = (addr / 32) % 8;
      bank0   = (m_ba == 0);
      lowrom  = bank0 && addr >= 'hF800;
      highrom = m_ba >= (1 << (BANK_W - 1));
      io      = bank0 && addr >= 'hF000 && addr < 'hF800 && vda;
      ram     = !lowrom && !highrom && !io;
      ram2    = ram && (((m_ba >> (BANK_W - 2)) & 1) == 1);
      exp_sel = '1;
      if (io && slot < IO_SLOTS && !(wsreg && slot == 0)) exp_sel[slot] = 1'b0;
      if (lowrom || highrom) ws = m_rom_ws;
      else if (io)           ws = IO_WS;
      else                   ws = RAM_WS;

      check("ba",    32'(bus.BA),      32'(m_ba));
      check("rdy",   32'(bus.RDY),     32'(m_wait == 0));
      check("romcs", 32'(bus.nROMCS),  32'(!(lowrom || highrom)));
      check("ram1",  32'(bus.nRAM1CS), 32'(!(ram && !ram2)));
      check("ram2",  32'(bus.nRAM2CS), 32'(!ram2));
      check("iosel", 32'(bus.nIOSEL),  32'(exp_sel));
      check("rd_lo", 32'({bus.nRD, bus.nWR}), 32'(2'b11));
      @(posedge phi2);
      #1;
      check("rd_hi", 32'({bus.nRD, bus.nWR}), 32'({!rw, rw}));

      if (rst) begin
         m_ba = 0; m_wait = 0; m_rom_ws = ROM_WS;
      end else if (m_wait > 0) begin
         m_wait--;
      end else begin
         if (vda || vpa) begin
            m_ba   = d;
            m_wait = ws % (1 << WS_W);
         end
         if (wsreg && io && slot == 0 && !rw) m_rom_ws = d % (1 << WS_W);
      end
   endtask

   initial begin
      logic [10:0] a;
      logic [7:0]  d;
      bit          vda, vpa;
      n_vec = 0; n_bad = 0;
      m_ba = 0; m_wait = 0; m_rom_ws = ROM_WS;
      reset = 1'b1;
      bus.ADDR = '0; bus.DB = '0; bus.nRW = 1'b1; bus.VDA = 1'b0; bus.VPA = 1'b0;
      @(posedge phi2);

      // reset with a valid cycle and all-ones bank on the bus
      step(1, 11'h7FF, 8'hFF, 1, 1, 0);
      step(1, 11'h7FF, 8'hFF, 1, 1, 0);
      check("rst_ba",  32'(bus.BA), 32'h0);
      check("rst_rdy", 32'(bus.RDY), 32'h1);
      check("rst_rom", 32'(bus.nROMCS), 32'h0);

      // bank latch into RAM2, then high ROM
      step(0, 11'h200, 8'h40, 1, 1, 0);
      check("b40_ba",   32'(bus.BA), 32'h40);
      check("b40_ram2", 32'(bus.nRAM2CS), 32'h0);
      check("b40_ram1", 32'(bus.nRAM1CS), 32'h1);
      check("b40_rdy",  32'(bus.RDY), 32'h1);
      step(0, 11'h200, 8'h80, 0, 1, 0);
      check("b80_rom",  32'(bus.nROMCS), 32'h0);
      check("b80_rdy",  32'(bus.RDY), 32'h1);
      for (int i = 0; i < 4; i++) step(0, 11'h200, 8'h00, 1, 1, 0);

      // I/O slot 3, then same address as a program fetch
      step(0, 11'h783, 8'h00, 1, 1, 0);
      check("io3_sel", 32'(bus.nIOSEL), 32'hF7);
      check("io3_ram", 32'({bus.nRAM1CS, bus.nRAM2CS}), 32'h3);
      for (int i = 0; i < 5; i++) step(0, 11'h783, 8'h00, 1, 1, 0);
      step(0, 11'h783, 8'h00, 1, 0, 1);
      check("vpa_sel",  32'(bus.nIOSEL), 32'hFF);
      check("vpa_ram1", 32'(bus.nRAM1CS), 32'h0);

      // ROM fetch at $FFFC: two wait cycles, bank held against DB=55
      step(0, 11'h7FF, 8'h00, 1, 0, 1);
      check("rom_w1", 32'(bus.RDY), 32'h0);
      step(0, 11'h7FF, 8'h55, 1, 1, 1);
      check("rom_w2", 32'(bus.RDY), 32'h0);
      step(0, 11'h7FF, 8'h55, 1, 1, 1);
      check("rom_end", 32'(bus.RDY), 32'h1);
      check("rom_ba",  32'(bus.BA), 32'h0);

      // reset in the middle of an I/O wait
      step(0, 11'h781, 8'h00, 1, 1, 0);
      step(0, 11'h781, 8'h00, 1, 1, 0);
      step(0, 11'h781, 8'h00, 1, 1, 0);
      check("mid_wait", 32'(bus.RDY), 32'h0);
      step(1, 11'h781, 8'h00, 1, 1, 0);
      check("mid_rdy", 32'(bus.RDY), 32'h1);
      check("mid_ba",  32'(bus.BA), 32'h0);

`ifdef JIGL_WSREG_EN
      step(0, 11'h780, 8'h03, 0, 1, 0);
      check("wr_sel0", 32'(bus.nIOSEL[0]), 32'h1);
      for (int i = 0; i < 5; i++) step(0, 11'h200, 8'h00, 1, 0, 0);
      step(0, 11'h7FF, 8'h00, 1, 0, 1);
      for (int i = 0; i < 3; i++) begin
         check("reg_ws3", 32'(bus.RDY), 32'h0);
         step(0, 11'h7FF, 8'h00, 1, 0, 1);
      end
      check("reg_ws3e", 32'(bus.RDY), 32'h1);
      step(1, 11'h200, 8'h00, 1, 0, 0);
      step(0, 11'h7FF, 8'h00, 1, 0, 1);
      for (int i = 0; i < 2; i++) begin
         check("reg_ws2", 32'(bus.RDY), 32'h0);
         step(0, 11'h7FF, 8'h00, 1, 0, 1);
      end
      check("reg_ws2e", 32'(bus.RDY), 32'h1);
`endif

      // random traffic biased toward bank 0 and the ROM/I/O windows
      for (int i = 0; i < 600; i++) begin
         a = 11'($urandom_range(0, 2047));
         case ($urandom_range(0, 3))
            0: a[10:6] = 5'b11111;
            1: a[10:6] = 5'b11110;
            default: ;
         endcase
         d = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 2) == 0) d = 8'h00;
         vda = 1'($urandom_range(0, 1));
         vpa = 1'($urandom_range(0, 1));
         step($urandom_range(0, 39) == 0, a, d, 1'($urandom_range(0, 1)), vda, vpa);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
